// File: rtl/spi_pixel_buffer.sv
// ---------------------------------------------------------------------------
// spi_pixel_buffer
//   SPI-slave (mode 0) front end plus a double-buffered pixel RAM that feeds
//   a ws2812 serializer. The host writes RGB frames into the back bank over
//   SPI. A SHOW command swaps the banks and pulses start_o. The serializer
//   reads the front bank through data_request_i/address_i while the host
//   refills the back bank.
//
// Ports
//   clk_i, reset_ni          system clock, async active-low reset
//   sclk_i, cs_ni, mosi_i    SPI inputs (async to clk_i, synchronised here)
//   miso_o                   SPI status byte {busy, swap_pending, front, 5'b0}
//   busy_i                   serializer busy
//   data_request_i/address_i serializer pixel read request and LED index
//   red_o/green_o/blue_o     registered front-bank pixel
//   start_o                  one-cycle start pulse to the serializer
//   led_count_o              active LED count
//
// Host commands (first byte of a chip-select frame)
//   0x01  pixel write: following bytes are R,G,B,R,G,B,... from pixel 0
//   0x02  LED count: the next byte sets led_count_o (saturated)
//   0x03  show: swap banks and start the serializer
// ---------------------------------------------------------------------------
module spi_pixel_buffer #(
    parameter  int NUM_LEDS = 8,
    localparam int ADDR_W   = $clog2(NUM_LEDS)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              sclk_i,
    input  logic              cs_ni,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic              busy_i,
    input  logic              data_request_i,
    input  logic [ADDR_W-1:0] address_i,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o,
    output logic              start_o,
    output logic [ADDR_W-1:0] led_count_o
);

    localparam int                LED_MAX    = 2**ADDR_W - 1;
    localparam logic [ADDR_W:0]   NUM_LEDS_W = (ADDR_W+1)'(NUM_LEDS);
    localparam logic [7:0]        CMD_WRITE  = 8'h01;
    localparam logic [7:0]        CMD_COUNT  = 8'h02;
    localparam logic [7:0]        CMD_SHOW   = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_COUNT,
        S_DISCARD
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronisers. Index [1] is the synced value, [2] the previous synced
    // value used for edge detection. cs resets high so leaving reset never
    // looks like a frame start.
    // -----------------------------------------------------------------------
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            sclk_q <= {sclk_q[1:0], sclk_i};
            cs_q   <= {cs_q[1:0], cs_ni};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_active;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_active = ~cs_q[1];

    // -----------------------------------------------------------------------
    // Shift registers
    // -----------------------------------------------------------------------
    logic [7:0] rx;
    logic [7:0] tx;
    logic [2:0] bit_cnt;
    logic       rx_valid;
    logic       front;
    logic       swap_pending;
    logic [7:0] status;

    assign status = {busy_i, swap_pending, front, 5'b0};

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx       <= '0;
            tx       <= '0;
            bit_cnt  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (cs_rise) begin
                // A partial byte is simply abandoned.
                bit_cnt <= '0;
            end else if (cs_fall) begin
                bit_cnt <= '0;
                tx      <= status;
            end else if (cs_active) begin
                if (sclk_rise) begin
                    rx      <= {rx[6:0], mosi_q[1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_valid <= 1'b1;
                        tx       <= status;
                    end
                end else if (sclk_fall) begin
                    tx <= {tx[6:0], 1'b0};
                end
            end
        end
    end

    assign miso_o = cs_active & tx[7];

    // -----------------------------------------------------------------------
    // Command FSM
    // -----------------------------------------------------------------------
    state_t state_q, state_d;
    logic   show_req;
    logic   ptr_clr;
    logic   wr_en;
    logic   count_we;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d  = state_q;
        show_req = 1'b0;
        ptr_clr  = 1'b0;
        wr_en    = 1'b0;
        count_we = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cs_fall) state_d = S_CMD;
            end
            S_CMD: begin
                if (rx_valid) begin
                    case (rx)
                        CMD_WRITE: begin
                            state_d = S_WRITE;
                            ptr_clr = 1'b1;
                        end
                        CMD_COUNT: state_d = S_COUNT;
                        CMD_SHOW: begin
                            show_req = 1'b1;
                            state_d  = S_DISCARD;
                        end
                        default:   state_d = S_DISCARD;
                    endcase
                end
            end
            S_WRITE: begin
                wr_en = rx_valid;
            end
            S_COUNT: begin
                if (rx_valid) begin
                    count_we = 1'b1;
                    state_d  = S_DISCARD;
                end
            end
            S_DISCARD: ;
            default:   state_d = S_IDLE;
        endcase
        if (cs_rise) state_d = S_IDLE;
    end

    // -----------------------------------------------------------------------
    // Write pointer: pixel index plus colour channel, saturating at the end
    // of the bank instead of wrapping back to pixel 0.
    // -----------------------------------------------------------------------
    logic [ADDR_W:0]   pix;
    logic [1:0]        chan;
    logic              ptr_full;
    logic              ram_we;
    logic [ADDR_W-1:0] pix_idx;

    assign ptr_full = (pix == NUM_LEDS_W);
    assign ram_we   = wr_en & ~ptr_full;
    assign pix_idx  = pix[ADDR_W-1:0];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pix  <= '0;
            chan <= '0;
        end else if (ptr_clr) begin
            pix  <= '0;
            chan <= '0;
        end else if (ram_we) begin
            if (chan == 2'd2) begin
                chan <= '0;
                pix  <= pix + 1'b1;
            end else begin
                chan <= chan + 2'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pixel RAM, two banks. Host writes always target the back bank (~front)
    // and reads always target the front bank, so they never collide.
    // -----------------------------------------------------------------------
    logic [7:0] mem_r [2][NUM_LEDS];
    logic [7:0] mem_g [2][NUM_LEDS];
    logic [7:0] mem_b [2][NUM_LEDS];
    logic       back;

    assign back = ~front;

    // NOTE: the RAM has no reset; its contents are undefined until the host
    // writes a frame, which lets it map onto plain memory.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            case (chan)
                2'd0:    mem_r[back][pix_idx] <= rx;
                2'd1:    mem_g[back][pix_idx] <= rx;
                2'd2:    mem_b[back][pix_idx] <= rx;
                default: ;
            endcase
        end
    end

    // Read port: a swap in the same cycle still sees the pre-swap front, and
    // a later swap never touches the already registered pixel.
    logic addr_ok;

    assign addr_ok = ({1'b0, address_i} < NUM_LEDS_W);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
        end else if (data_request_i) begin
            if (addr_ok) begin
                red_o   <= mem_r[front][address_i];
                green_o <= mem_g[front][address_i];
                blue_o  <= mem_b[front][address_i];
            end else begin
                red_o   <= '0;
                green_o <= '0;
                blue_o  <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bank swap and start pulse. A SHOW swaps at once unless the serializer
    // is busy or a start went out in the last two cycles; otherwise it is
    // remembered in swap_pending and serviced once busy_i drops. A SHOW and
    // a pending service in the same cycle yield a single swap.
    // -----------------------------------------------------------------------
    logic start_d;
    logic do_swap;

    assign do_swap = ~busy_i & ((show_req & ~start_o & ~start_d) |
                                (swap_pending & ~start_o));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            front        <= 1'b0;
            swap_pending <= 1'b0;
            start_o      <= 1'b0;
            start_d      <= 1'b0;
        end else begin
            start_o <= do_swap;
            start_d <= start_o;
            if (do_swap) begin
                front        <= ~front;
                swap_pending <= 1'b0;
            end else if (show_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // LED count, saturated to the largest index the address bus can carry.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            led_count_o <= ADDR_W'(LED_MAX);
        end else if (count_we) begin
            led_count_o <= (rx > 8'(LED_MAX)) ? ADDR_W'(LED_MAX) : rx[ADDR_W-1:0];
        end
    end

endmodule

// File: tb/tb_spi_pixel_buffer.sv
// ---------------------------------------------------------------------------
// tb_spi_pixel_buffer
//   Directed bench for spi_pixel_buffer. Drives SPI mode 0 with sclk at
//   1/16 of clk, writes frames, swaps banks and reads pixels back. Table
//   vectors cover pixel reads and LED-count saturation; hand-written
//   sequences cover busy/pending swaps, write overflow, aborted bytes,
//   reads during host writes and reset mid-byte.
// ---------------------------------------------------------------------------
module tb_spi_pixel_buffer;

    localparam int NUM_LEDS = 8;
    localparam int ADDR_W   = 3;

    logic              clk_i          = 1'b0;
    logic              reset_ni       = 1'b0;
    logic              sclk_i         = 1'b0;
    logic              cs_ni          = 1'b1;
    logic              mosi_i         = 1'b0;
    logic              busy_i         = 1'b0;
    logic              data_request_i = 1'b0;
    logic [ADDR_W-1:0] address_i      = '0;
    logic              miso_o;
    logic [7:0]        red_o, green_o, blue_o;
    logic              start_o;
    logic [ADDR_W-1:0] led_count_o;

    spi_pixel_buffer #(.NUM_LEDS(NUM_LEDS)) dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .sclk_i         (sclk_i),
        .cs_ni          (cs_ni),
        .mosi_i         (mosi_i),
        .miso_o         (miso_o),
        .busy_i         (busy_i),
        .data_request_i (data_request_i),
        .address_i      (address_i),
        .red_o          (red_o),
        .green_o        (green_o),
        .blue_o         (blue_o),
        .start_o        (start_o),
        .led_count_o    (led_count_o)
    );

    always #5 clk_i = ~clk_i;

    int total     = 0;
    int passed    = 0;
    int start_cnt = 0;

    // Cycles with start_o high; a single clean pulse adds exactly one.
    always @(negedge clk_i) begin
        if (start_o === 1'b1) start_cnt++;
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [23:0]       rgb;
    } pix_vec_t;

    typedef struct {
        logic [7:0]        arg;
        logic [ADDR_W-1:0] cnt;
    } cnt_vec_t;

    pix_vec_t pix_tab[4];
    cnt_vec_t cnt_tab[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Shift n bits of b (MSB first); returns the miso bits seen at each
    // rising sclk, unused low bits left at 0.
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] seen);
        seen = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi_i = b[7-i];
            wait_clks(6);
            seen[7-i] = miso_o;
            sclk_i = 1'b1;
            wait_clks(8);
            sclk_i = 1'b0;
            wait_clks(2);
        end
    endtask

    task automatic spi_begin();
        cs_ni = 1'b0;
        wait_clks(8);
    endtask

    task automatic spi_end();
        wait_clks(8);
        cs_ni = 1'b1;
        wait_clks(8);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] dummy;
        spi_bits(b, 8, dummy);
    endtask

    task automatic show();
        spi_begin();
        send_byte(8'h03);
        spi_end();
    endtask

    task automatic read_pix(input logic [ADDR_W-1:0] a, output logic [23:0] v);
        data_request_i = 1'b1;
        address_i      = a;
        wait_clks(1);
        data_request_i = 1'b0;
        v = {red_o, green_o, blue_o};
    endtask

    function automatic logic [23:0] fill_pix(input logic [7:0] base, input int p);
        logic [7:0] r;
        r = base + 8'(3*p);
        return {r, r + 8'd1, r + 8'd2};
    endfunction

    logic [7:0]  st;
    logic [23:0] rgb;
    int          base;

    initial begin
        pix_tab[0] = '{addr: 3'd2, rgb: 24'h060708};
        pix_tab[1] = '{addr: 3'd0, rgb: 24'h000102};
        pix_tab[2] = '{addr: 3'd7, rgb: 24'h151617};
        pix_tab[3] = '{addr: 3'd5, rgb: 24'h0F1011};

        cnt_tab[0] = '{arg: 8'h05, cnt: 3'd5};
        cnt_tab[1] = '{arg: 8'hFF, cnt: 3'd7};
        cnt_tab[2] = '{arg: 8'h00, cnt: 3'd0};
        cnt_tab[3] = '{arg: 8'h07, cnt: 3'd7};
        cnt_tab[4] = '{arg: 8'h08, cnt: 3'd7};

        // Reset values
        wait_clks(3);
        check("rst_miso",  32'(miso_o), 32'h0);
        check("rst_start", 32'(start_o), 32'h0);
        check("rst_rgb",   32'({red_o, green_o, blue_o}), 32'h0);
        check("rst_count", 32'(led_count_o), 32'h7);
        reset_ni = 1'b1;
        wait_clks(4);

        // Frame 0x00..0x17 into the back bank, then SHOW with busy low
        spi_begin();
        send_byte(8'h01);
        for (int k = 0; k < 24; k++) send_byte(8'(k));
        spi_end();
        base = start_cnt;
        show();
        wait_clks(4);
        check("show_one_pulse", 32'(start_cnt - base), 32'd1);

        for (int i = 0; i < 4; i++) begin
            read_pix(pix_tab[i].addr, rgb);
            check($sformatf("frame1_pix%0d", pix_tab[i].addr), 32'(rgb), 32'(pix_tab[i].rgb));
        end

        // LED count with saturation
        for (int i = 0; i < 5; i++) begin
            spi_begin();
            send_byte(8'h02);
            send_byte(cnt_tab[i].arg);
            spi_end();
            check($sformatf("count_%02h", cnt_tab[i].arg), 32'(led_count_o), 32'(cnt_tab[i].cnt));
        end

        // SHOW while busy: no pulse, request held pending
        busy_i = 1'b1;
        base = start_cnt;
        show();
        wait_clks(10);
        check("busy_no_start", 32'(start_cnt - base), 32'd0);
        spi_begin();
        spi_bits(8'h00, 8, st);
        spi_end();
        check("status_pending", 32'(st), 32'hE0);
        busy_i = 1'b0;
        wait_clks(1);
        check("pending_start_hi", 32'(start_o), 32'h1);
        wait_clks(1);
        check("pending_start_lo", 32'(start_o), 32'h0);
        spi_begin();
        spi_bits(8'h00, 8, st);
        spi_end();
        check("status_swapped", 32'(st), 32'h00);

        // 30-byte write: bytes 24..29 dropped, no wrap into pixel 0
        spi_begin();
        send_byte(8'h01);
        for (int k = 0; k < 30; k++) send_byte(8'h40 + 8'(k));
        spi_end();
        show();
        read_pix(3'd0, rgb);
        check("ovf_pix0", 32'(rgb), 32'h404142);
        read_pix(3'd7, rgb);
        check("ovf_pix7", 32'(rgb), 32'h555657);

        // Aborted byte: fill back bank, start a rewrite, cut cs after 5 bits
        spi_begin();
        send_byte(8'h01);
        for (int k = 0; k < 24; k++) send_byte(8'h80 + 8'(k));
        spi_end();
        spi_begin();
        send_byte(8'h01);
        send_byte(8'hC0);
        send_byte(8'hC1);
        send_byte(8'hC2);
        spi_bits(8'hFF, 5, st);
        spi_end();
        spi_begin();
        send_byte(8'h02);
        send_byte(8'h03);
        spi_end();
        check("abort_next_is_cmd", 32'(led_count_o), 32'h3);
        show();
        read_pix(3'd0, rgb);
        check("abort_pix0", 32'(rgb), 32'hC0C1C2);
        read_pix(3'd1, rgb);
        check("abort_pix1", 32'(rgb), 32'h838485);

        // Busy: refill back bank while reading every front pixel
        busy_i = 1'b1;
        base = start_cnt;
        spi_begin();
        send_byte(8'h01);
        for (int k = 0; k < 24; k++) begin
            send_byte(8'hE0 + 8'(k));
            if (k < 8) begin
                read_pix(3'(k), rgb);
                check($sformatf("busy_read%0d", k), 32'(rgb),
                      32'((k == 0) ? 24'hC0C1C2 : fill_pix(8'h80, k)));
            end
        end
        spi_end();
        check("busy_write_no_start", 32'(start_cnt - base), 32'd0);
        busy_i = 1'b0;

        // Reset in the middle of a byte
        spi_begin();
        send_byte(8'h01);
        spi_bits(8'hFF, 3, st);
        reset_ni = 1'b0;
        #1;
        check("midrst_miso",  32'(miso_o), 32'h0);
        check("midrst_start", 32'(start_o), 32'h0);
        check("midrst_rgb",   32'({red_o, green_o, blue_o}), 32'h0);
        check("midrst_count", 32'(led_count_o), 32'h7);
        cs_ni  = 1'b1;
        sclk_i = 1'b0;
        wait_clks(3);
        reset_ni = 1'b1;
        wait_clks(4);
        spi_begin();
        spi_bits(8'h00, 8, st);
        spi_end();
        check("postrst_status", 32'(st), 32'h00);
        spi_begin();
        send_byte(8'h02);
        send_byte(8'h05);
        spi_end();
        check("postrst_count", 32'(led_count_o), 32'h5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
